// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - ALU operation encoding shared by the CPU blocks
package cpu_pkg;

    typedef enum logic [2:0] {
        Operation_ADD,
        Operation_SUB,
        Operation_NOR,
        Operation_NAND,
        Operation_XOR,
        Operation_XNOR
    } Operation;

endpackage

// File: rtl/cpu_control.sv
// rtl/cpu_control.sv - fetch/decode/execute sequencer for the 8-bit accumulator CPU (optional CPU_SINGLE_STEP_EN)
module cpu_control
    import cpu_pkg::*;
#(
    parameter int                  PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                _iClk,
    input  logic                _iReset,
`ifdef CPU_SINGLE_STEP_EN
    input  logic                _iStep,
`endif
    output logic [PC_WIDTH-1:0] _oPc,
    input  logic [15:0]         _iInstr,
    output logic [7:0]          _oMemAddr,
    output logic [7:0]          _oMemWData,
    output logic                _oMemRd,
    output logic                _oMemWr,
    input  logic [7:0]          _iMemRData,
    input  logic                _iMemAck,
    output logic [7:0]          _oAluA,
    output logic [7:0]          _oAluB,
    output logic                _oAluC,
    output Operation            _oAluOp,
    input  logic [7:0]          _iAluResult,
    input  logic                _iAluCarry,
    input  logic                _iAluZero,
    input  logic                _iAluNeg,
    output logic [7:0]          _oAcc,
    output logic [2:0]          _oFlags,
    output logic                _oHalted
);

    localparam logic [3:0] OP_LDA  = 4'h1;
    localparam logic [3:0] OP_STA  = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_SUB  = 4'h4;
    localparam logic [3:0] OP_NOR  = 4'h5;
    localparam logic [3:0] OP_NAND = 4'h6;
    localparam logic [3:0] OP_XOR  = 4'h7;
    localparam logic [3:0] OP_XNOR = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_JZ   = 4'hA;
    localparam logic [3:0] OP_JC   = 4'hB;
    localparam logic [3:0] OP_JN   = 4'hC;
    localparam logic [3:0] OP_HLT  = 4'hF;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_MEM,
        S_EXEC,
        S_HALT
`ifdef CPU_SINGLE_STEP_EN
        , S_STEP
`endif
    } state_t;

    // Where the FSM goes whenever a new fetch is due (gated by a step pulse when stepping)
`ifdef CPU_SINGLE_STEP_EN
    localparam state_t S_NEXT = S_STEP;
`else
    localparam state_t S_NEXT = S_FETCH;
`endif

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [15:0]         instr_q, instr_d;
    logic [7:0]          acc_q, acc_d;
    logic [2:0]          flags_q, flags_d;      // {C,Z,N}
    logic [7:0]          operand_q, operand_d;
    logic                mem_rd_q, mem_rd_d;
    logic                mem_wr_q, mem_wr_d;
    logic [7:0]          mem_addr_q, mem_addr_d;
    logic [7:0]          mem_wdata_q, mem_wdata_d;
    logic                halted_q, halted_d;
`ifdef CPU_SINGLE_STEP_EN
    logic                step_prev_q;
`endif

    // Fields of the latched instruction (used from MEM onwards)
    logic [3:0] instr_op;
    logic       instr_m;
    logic       instr_k;
    logic [7:0] instr_imm;
    assign instr_op  = instr_q[15:12];
    assign instr_m   = instr_q[11];
    assign instr_k   = instr_q[10];
    assign instr_imm = instr_q[7:0];

    // Fields of the ROM word, only meaningful in DECODE
    logic [3:0] dec_op;
    logic       dec_m;
    logic [7:0] dec_imm;
    assign dec_op  = _iInstr[15:12];
    assign dec_m   = _iInstr[11];
    assign dec_imm = _iInstr[7:0];

    logic unused_instr_bits;
    assign unused_instr_bits = ^{_iInstr[9:8], instr_q[9:8]};

    logic [7:0] alu_b;
    logic       alu_c;
    Operation   alu_op;
    logic       jump_taken;

    // ALU operand/op selection; non-ALU opcodes present ADD so the bus is always defined
    always_comb begin
        alu_b  = instr_m ? operand_q : instr_imm;
        alu_c  = 1'b0;
        alu_op = Operation_ADD;
        case (instr_op)
            OP_ADD:  begin alu_op = Operation_ADD; alu_c = instr_k & flags_q[2]; end
            OP_SUB:  begin alu_op = Operation_SUB; alu_c = instr_k & flags_q[2]; end
            OP_NOR:  alu_op = Operation_NOR;
            OP_NAND: alu_op = Operation_NAND;
            OP_XOR:  alu_op = Operation_XOR;
            OP_XNOR: alu_op = Operation_XNOR;
            default: ;
        endcase
    end

    // Branch decision against the flags as they stand while decoding
    always_comb begin
        jump_taken = 1'b0;
        case (dec_op)
            OP_JMP:  jump_taken = 1'b1;
            OP_JZ:   jump_taken = flags_q[1];
            OP_JC:   jump_taken = flags_q[2];
            OP_JN:   jump_taken = flags_q[0];
            default: jump_taken = 1'b0;
        endcase
    end

    // Sequencer next-state, datapath and registered memory-port outputs
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        acc_d       = acc_q;
        flags_d     = flags_q;
        operand_d   = operand_q;
        mem_rd_d    = mem_rd_q;
        mem_wr_d    = mem_wr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        halted_d    = halted_q;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                instr_d = _iInstr;
                pc_d    = pc_q + PC_WIDTH'(1);
                case (dec_op)
                    OP_JMP, OP_JZ, OP_JC, OP_JN: begin
                        if (jump_taken) begin
                            pc_d = PC_WIDTH'(dec_imm);
                        end
                        state_d = S_NEXT;
                    end
                    OP_HLT: begin
                        state_d  = S_HALT;
                        halted_d = 1'b1;
                    end
                    OP_STA: begin
                        if (dec_m) begin
                            state_d     = S_MEM;
                            mem_wr_d    = 1'b1;
                            mem_addr_d  = dec_imm;
                            mem_wdata_d = acc_q;
                        end else begin
                            state_d = S_NEXT;
                        end
                    end
                    OP_LDA, OP_ADD, OP_SUB, OP_NOR, OP_NAND, OP_XOR, OP_XNOR: begin
                        if (dec_m) begin
                            state_d    = S_MEM;
                            mem_rd_d   = 1'b1;
                            mem_addr_d = dec_imm;
                        end else begin
                            state_d = S_EXEC;
                        end
                    end
                    default: state_d = S_NEXT;
                endcase
            end
            S_MEM: begin
                if (_iMemAck) begin
                    mem_rd_d = 1'b0;
                    mem_wr_d = 1'b0;
                    if (instr_op == OP_STA) begin
                        state_d = S_NEXT;
                    end else begin
                        operand_d = _iMemRData;
                        state_d   = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                if (instr_op == OP_LDA) begin
                    acc_d   = alu_b;
                    flags_d = {flags_q[2], alu_b == 8'h00, alu_b[7]};
                end else begin
                    acc_d   = _iAluResult;
                    flags_d = {_iAluCarry, _iAluZero, _iAluNeg};
                end
                state_d = S_NEXT;
            end
            S_HALT: state_d = S_HALT;
`ifdef CPU_SINGLE_STEP_EN
            S_STEP: begin
                if (_iStep && !step_prev_q) begin
                    state_d = S_FETCH;
                end
            end
`endif
            default: state_d = S_NEXT;
        endcase
    end

    // State registers; reset wins over everything, including an open memory handshake
    always_ff @(posedge _iClk) begin
        if (_iReset) begin
            state_q     <= S_NEXT;
            pc_q        <= RESET_PC;
            instr_q     <= '0;
            acc_q       <= '0;
            flags_q     <= '0;
            operand_q   <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            acc_q       <= acc_d;
            flags_q     <= flags_d;
            operand_q   <= operand_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            halted_q    <= halted_d;
        end
    end

`ifdef CPU_SINGLE_STEP_EN
    // Step input history for edge detect; tracking the level through reset avoids a phantom step
    always_ff @(posedge _iClk) begin
        step_prev_q <= _iStep;
    end
`endif

    assign _oPc       = pc_q;
    assign _oMemAddr  = mem_addr_q;
    assign _oMemWData = mem_wdata_q;
    assign _oMemRd    = mem_rd_q;
    assign _oMemWr    = mem_wr_q;
    assign _oAluA     = acc_q;
    assign _oAluB     = alu_b;
    assign _oAluC     = alu_c;
    assign _oAluOp    = alu_op;
    assign _oAcc      = acc_q;
    assign _oFlags    = flags_q;
    assign _oHalted   = halted_q;

endmodule

// File: doc/cpu_control.md
Name: cpu_control

Overview:
- Multi-cycle fetch/decode/execute sequencer for the 8-bit accumulator CPU.
- Owns the PC, accumulator and C/Z/N flags, and drives the combinational ALU.
- Drives an Operation code, operands and carry-in to the ALU, then captures the result and flags it returns.
- Sits between the synchronous program ROM, the data-memory handshake port and the ALU in the cpu top level.

Parameters:
- PC_WIDTH, 8, program counter / ROM address width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- _iClk  in  1  system clock, all state on rising edge.
- _iReset  in  1  synchronous, active-high reset.
- _oPc  out  PC_WIDTH  program ROM address.
- _iInstr  in  16  ROM data, valid the cycle after _oPc is presented.
- _oMemAddr  out  8  data memory address.
- _oMemWData  out  8  store data.
- _oMemRd  out  1  read request, held until ack.
- _oMemWr  out  1  write request, held until ack.
- _iMemRData  in  8  read data, valid with _iMemAck.
- _iMemAck  in  1  one-cycle completion strobe.
- _oAluA  out  8  accumulator to ALU.
- _oAluB  out  8  operand to ALU.
- _oAluC  out  1  carry-in to ALU.
- _oAluOp  out  Operation  ALU operation (cpu_pkg).
- _iAluResult  in  8  ALU result.
- _iAluCarry  in  1  ALU carry flag.
- _iAluZero  in  1  ALU zero flag.
- _iAluNeg  in  1  ALU negative flag.
- _oAcc  out  8  accumulator, for debug/IO.
- _oFlags  out  3  {C,Z,N}.
- _oHalted  out  1  high in HALT state.

Behaviour:
- Reset and interface:
  - One clock; reset is synchronous and active-high.
  - On a clock edge with _iReset=1: PC=RESET_PC, acc=0, flags=000, state=FETCH, instr reg=0.
  - Also on that edge: _oMemRd=_oMemWr=0, _oMemAddr=0, _oMemWData=0, _oHalted=0.
  - Reset overrides any state, including MEM mid-handshake; the request drops on that same edge.
- Instruction format:
  - [15:12] opcode.
  - [11] M: 1 selects memory operand mem[imm]; 0 selects immediate imm.
  - [10] K: carry-in = C flag when 1, 0 when 0 (ADD/SUB only).
  - [9:8] ignored.
  - [7:0] imm / address.
- Opcodes:
  - 0 NOP.
  - 1 LDA.
  - 2 STA (requires M=1; M=0 executes as NOP).
  - 3 ADD, 4 SUB, 5 NOR, 6 NAND, 7 XOR, 8 XNOR.
  - 9 JMP, A JZ, B JC, C JN.
  - D, E reserved, execute as NOP.
  - F HLT.
- FSM:
  - FETCH: present _oPc; next state DECODE.
  - DECODE: latch _iInstr; PC<=PC+1, wrapping modulo 2^PC_WIDTH.
    - Taken jump: PC<=imm[PC_WIDTH-1:0], then FETCH.
    - Untaken jump or NOP: FETCH.
    - HLT: HALT.
    - M=1 with LDA/ALU op/STA: MEM.
    - Otherwise: EXEC.
  - MEM: _oMemAddr=imm.
    - STA drives _oMemWr=1 and _oMemWData=acc.
    - Other ops drive _oMemRd=1 and latch _iMemRData into the operand register on ack.
    - Stay in MEM until _iMemAck=1. On ack, STA goes to FETCH and others go to EXEC.
    - Requests deassert on the edge the ack is sampled.
  - EXEC:
    - ALU op: acc<=_iAluResult; flags<={_iAluCarry,_iAluZero,_iAluNeg}.
    - LDA: acc<=operand; Z,N from the operand; C unchanged.
    - Next state FETCH.
  - HALT: terminal until reset; _oHalted=1.
- Jump conditions use the flags as they stand at DECODE.
- _iMemAck outside MEM is ignored.
- ALU drive (combinational from registers):
  - _oAluA=acc.
  - _oAluB = operand register if M=1, else imm.
  - _oAluC = K & C for ADD/SUB, 0 otherwise.
  - _oAluOp decoded from opcode; Operation_ADD for non-ALU opcodes.
- Latency:
  - Immediate ALU/LDA: 3 cycles.
  - Memory ALU/LDA: 3 cycles plus wait cycles; 4 cycles with ack on the first MEM cycle.
  - STA: 3 cycles with ack on the first MEM cycle.
  - Jump/NOP: 2 cycles.

Optional Feature:
- Macro CPU_SINGLE_STEP_EN.
- When defined:
  - Adds input port _iStep (1 bit).
  - Each FETCH is entered only after an _iStep rising-edge detect (registered, one step per 0->1 transition); until then the FSM waits in state STEP.
  - Out of reset the FSM enters STEP instead of FETCH.
  - HALT is unaffected.
- When undefined: no port, no STEP state; timing exactly as above.

Test Plan:
- Reset, then ROM {0x1005 LDA #5, 0x3003 ADD #3, 0xF000} -> acc=0x08, flags=000, _oHalted=1 on cycle 8 after reset release.
- LDA #0xFF, ADD #0x01, then ADD K=1 #0x00 (0x3400) -> acc=0x00, C=1, Z=1 after the second instruction; acc=0x01, C=0 after the third.
- STA 0x3C (0x2A3C) with acc=0xA5 and ack delayed 3 cycles -> _oMemWr high exactly 4 cycles, _oMemWData=0xA5, _oMemAddr=0x3C, acc/flags unchanged.
- ADD mem 0x10 (0x3810) with mem=0x80, acc=0x80 -> _oMemRd until ack; result acc=0x00, C=1, Z=1, N=0.
- JZ 0x40 (0xA040) with Z=0, then Z=1 -> PC=next address / PC=0x40; each takes 2 cycles; PC=0xFF NOP wraps to 0x00.
- Assert _iReset during MEM wait -> next edge _oMemRd=0, PC=RESET_PC, acc=0; a late _iMemAck is ignored.
